// File: rtl/canright_inv_pipe.sv
// canright_inv_pipe
//   Pipelined, multi-lane GF(2^4) inverter built on the Canright tower
//   field: GF(2^4) over GF(2^2), both levels in normal basis. GF(2^2) uses
//   the basis {W^2, W}, with bit 1 holding the W^2 coefficient. The
//   GF(2^4) sum term is scaled by N = W^2.
//   Each lane computes
//     d = hi*lo ^ N*(hi^lo)^2 ; e = d^-1 ; out = {e*lo, e*hi}
//   The output register is always present. STAGES=2 adds a register after
//   the GF(4) sum. STAGES=3 adds another register after the GF(4) inverse.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_data[4*LANES]     lane i = in_data[4i+3:4i], {hi[3:2], lo[1:0]}
//   in_tag[TAG_W]        sideband, returned unchanged with its beat
//   out_valid/out_ready  output handshake
//   out_data[4*LANES]    lane i = GF(2^4) inverse of input lane i (0 -> 0)
//   out_tag[TAG_W]       tag of the beat on out_data
//   cnt_clr              synchronous clear of beat_cnt (beats a handshake)
//   beat_cnt[16]         count of output handshakes, wraps
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both 1. Once valid is raised, the beat is held stable until
// it is taken. ready never depends on valid on the same interface.
// Each stage k is ready when it is empty or when the stage below it is ready.
// As a result, bubbles collapse even while the output is stalled.
module canright_inv_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 cnt_clr,
  output logic [15:0]          beat_cnt
);

  localparam int DW = 4 * LANES;
  // Intermediate lane payload: {hi, lo, d} or {hi, lo, e}.
  localparam int MW = 6 * LANES;

  // GF(2^2) normal-basis multiply.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic s;
    s = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ s, (a[0] & b[0]) ^ s};
  endfunction

  // Square and then scale by N = W^2.
  function automatic logic [1:0] gf4_sqscl(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // In normal basis, inversion in GF(2^2) is squaring, which is a bit swap.
  function automatic logic [1:0] gf4_inv(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [MW-1:0] f_sum(input logic [DW-1:0] x);
    logic [MW-1:0] r;
    logic [1:0]    hi, lo;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      hi = x[4*i+2 +: 2];
      lo = x[4*i   +: 2];
      r[6*i +: 6] = {hi, lo, gf4_mul(hi, lo) ^ gf4_sqscl(hi ^ lo)};
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] f_inv(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[6*i +: 6] = {m[6*i+2 +: 4], gf4_inv(m[6*i +: 2])};
    return r;
  endfunction

  function automatic logic [DW-1:0] f_out(input logic [MW-1:0] m);
    logic [DW-1:0] r;
    logic [1:0]    hi, lo, e;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      hi = m[6*i+4 +: 2];
      lo = m[6*i+2 +: 2];
      e  = m[6*i   +: 2];
      r[4*i +: 4] = {gf4_mul(e, lo), gf4_mul(e, hi)};
    end
    return r;
  endfunction

  logic [STAGES:1] v;
  logic [STAGES:1] uv;
  logic [STAGES:1] rdy;
  logic [STAGES:1] ld;
  logic [TAG_W-1:0] tag_r [1:STAGES];
  logic [TAG_W-1:0] utag  [1:STAGES];
  logic [DW-1:0]    out_r;
  logic [DW-1:0]    out_nxt;

  // Upstream valid/tag for each stage. Stage 1 is fed by the input port.
  always_comb begin
    uv      = '0;
    uv[1]   = in_valid;
    utag[1] = in_tag;
    for (int k = 2; k <= STAGES; k++) begin
      uv[k]   = v[k-1];
      utag[k] = tag_r[k-1];
    end
  end

  // Ready chain, evaluated from the output back toward the input.
  always_comb begin
    logic r;
    rdy = '0;
    r   = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      r      = !v[k] | r;
      rdy[k] = r;
    end
  end

  assign ld = rdy & uv;

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("canright_inv_pipe: STAGES must be 1..3, got %0d", STAGES);
  end

  if (STAGES == 1) begin : g_s1
    assign out_nxt = f_out(f_inv(f_sum(in_data)));
  end else if (STAGES == 2) begin : g_s2
    logic [MW-1:0] m1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        m1 <= '0;
      else if (ld[1]) m1 <= f_sum(in_data);
    end
    assign out_nxt = f_out(f_inv(m1));
  end else if (STAGES == 3) begin : g_s3
    logic [MW-1:0] m1, m2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m1 <= '0;
        m2 <= '0;
      end else begin
        if (ld[1]) m1 <= f_sum(in_data);
        if (ld[2]) m2 <= f_inv(m1);
      end
    end
    assign out_nxt = f_out(m2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      out_r <= '0;
      for (int k = 1; k <= STAGES; k++) tag_r[k] <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) v[k]     <= uv[k];
        if (ld[k])  tag_r[k] <= utag[k];
      end
      if (ld[STAGES]) out_r <= out_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         beat_cnt <= '0;
    else if (cnt_clr)                beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
  end

  assign in_ready  = rdy[1];
  assign out_valid = v[STAGES];
  assign out_data  = out_r;
  assign out_tag   = tag_r[STAGES];

endmodule

// File: tb/tb_canright_inv_pipe.sv
// Testbench for canright_inv_pipe (LANES=4, STAGES=2, TAG_W=4).
// The reference model builds GF(2^2) arithmetic from discrete logarithms
// (W^k), then builds the GF(2^4) tower product on top of it. Inverses are
// found by exhaustive search for the element whose product with x is one.
module tb_canright_inv_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int DW     = 4 * LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             cnt_clr;
  logic [15:0]      beat_cnt;

  canright_inv_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // GF(2^2) element codes: 2'b11 = 1 = W^0, 2'b01 = W, 2'b10 = W^2.
  logic [1:0] pw [3];
  logic [3:0] inv_tab [16];

  function automatic int gf4_log(input logic [1:0] a);
    for (int k = 0; k < 3; k++) if (pw[k] == a) return k;
    return 0;
  endfunction

  function automatic logic [1:0] m_gf4_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    return pw[(gf4_log(a) + gf4_log(b)) % 3];
  endfunction

  // x = h*Y^4 + l*Y, with Y^2 + Y + N = 0 and N = W^2.
  function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] t;
    t = m_gf4_mul(m_gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
    return {m_gf4_mul(x[3:2], y[3:2]) ^ t, m_gf4_mul(x[1:0], y[1:0]) ^ t};
  endfunction

  task automatic build_model();
    pw[0] = 2'b11; pw[1] = 2'b01; pw[2] = 2'b10;
    inv_tab[0] = 4'h0;
    for (int x = 1; x < 16; x++) begin
      inv_tab[x] = 4'h0;
      for (int y = 1; y < 16; y++)
        if (gf16_mul(4'(x), 4'(y)) == 4'hF) inv_tab[x] = 4'(y);
    end
  endtask

  function automatic logic [DW-1:0] model_vec(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[4*i +: 4] = inv_tab[x[4*i +: 4]];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    in_q[$];
  logic [TAG_W-1:0] tag_q[$];
  logic [DW-1:0]    lb_exp_q[$];
  logic [DW-1:0]    sweep_out[$];
  bit               lb_mode = 0;
  bit               record_out = 0;
  logic [15:0]      model_cnt;
  bit               prev_stall;
  logic [DW-1:0]    prev_data, sb_exp, sb_in;
  logic [TAG_W-1:0] prev_tag, sb_tag;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); in_q.delete(); tag_q.delete(); lb_exp_q.delete();
      model_cnt  = 16'd0;
      prev_stall = 1'b0;
    end else begin
      chk("beat_cnt", beat_cnt, model_cnt);
      if (prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_tag", out_tag, prev_tag);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_vec(in_data));
        in_q.push_back(in_data);
        tag_q.push_back(in_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'd1, 32'd0);
        end else begin
          sb_exp = exp_q.pop_front();
          sb_in  = in_q.pop_front();
          sb_tag = tag_q.pop_front();
          chk("out_data", out_data, sb_exp);
          chk("out_tag", out_tag, sb_tag);
          for (int i = 0; i < LANES; i++)
            if (sb_in[4*i +: 4] != 4'h0)
              chk("lane_product", gf16_mul(sb_in[4*i +: 4], out_data[4*i +: 4]), 4'hF);
          if (lb_mode && lb_exp_q.size() != 0) chk("loopback", out_data, lb_exp_q.pop_front());
          if (record_out) sweep_out.push_back(out_data);
        end
      end
      if (cnt_clr)                     model_cnt = 16'd0;
      else if (out_valid && out_ready) model_cnt = model_cnt + 16'd1;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  // ---------------- drivers ----------------
  bit rnd_ready = 0;
  int ready_pct = 100;

  task automatic step(output bit hs);
    @(negedge clk);
    hs = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic idle(input int n);
    bit hs;
    for (int i = 0; i < n; i++) step(hs);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
    bit hs;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_tag = t;
    do begin
      step(hs);
      n++;
    end while (!hs && n < 300);
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_tag   = TAG_W'($urandom);
  endtask

  task automatic drain();
    bit hs;
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      if (!rnd_ready) out_ready = 1'b1;
      step(hs);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic rand_stream(input int n, input int vpct);
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(0, 99) >= vpct) idle(1);
      send(DW'($urandom), TAG_W'($urandom));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [DW-1:0] beats [8];
  logic [DW-1:0] bub_a, bub_b, d;
  int            idx, n;
  bit            hs;

  initial begin
    build_model();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Fixed points and latency: inv(F)=F, inv(0)=0
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hF0F0; in_tag = 4'd3;
    step(hs);
    chk("fix_hs", hs, 1);
    in_valid = 1'b0;
    chk("fix_lat1_valid", out_valid, 0);
    step(hs);
    chk("fix_lat2_valid", out_valid, 1);
    chk("fix_data", out_data, 16'hF0F0);
    chk("fix_tag", out_tag, 4'd3);
    drain();

    // Exhaustive sweep: every nibble value in every lane
    sweep_out.delete();
    record_out = 1'b1;
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < LANES; i++) d[4*i +: 4] = 4'(v + 5 * i);
      send(d, 4'(v));
    end
    drain();
    record_out = 1'b0;
    chk("sweep_count", sweep_out.size(), 16);

    // Loopback: inverting the outputs must give back the originals
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < LANES; i++) d[4*i +: 4] = 4'(v + 5 * i);
      lb_exp_q.push_back(d);
    end
    lb_mode = 1'b1;
    rnd_ready = 1'b1; ready_pct = 60;
    for (int k = 0; k < sweep_out.size(); k++) send(sweep_out[k], 4'(k));
    drain();
    chk("loopback_all_seen", lb_exp_q.size(), 0);
    lb_mode = 1'b0;
    rnd_ready = 1'b0;

    // Backpressure: 8 beats, output stalled for 5 cycles
    out_ready = 1'b0;
    cnt_clr = 1'b1; step(hs); cnt_clr = 1'b0;
    for (int k = 0; k < 8; k++) beats[k] = DW'($urandom);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = beats[idx]; in_tag = 4'(idx);
      step(hs);
      if (hs) idx++;
    end
    chk("bp_held", idx, STAGES);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, model_vec(beats[0]));
    out_ready = 1'b1;
    n = 0;
    while (idx < 8 && n < 100) begin
      in_valid = 1'b1; in_data = beats[idx]; in_tag = 4'(idx);
      step(hs);
      if (hs) idx++;
      n++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 8);
    drain();
    chk("bp_beat_cnt", beat_cnt, 8);

    // Bubble collapse: valid pattern 1,0,1 with output stalled
    out_ready = 1'b0;
    bub_a = DW'($urandom); bub_b = DW'($urandom);
    in_valid = 1'b1; in_data = bub_a; in_tag = 4'hA;
    step(hs);
    chk("bub_a_hs", hs, 1);
    in_valid = 1'b0; in_data = DW'($urandom);
    step(hs);
    in_valid = 1'b1; in_data = bub_b; in_tag = 4'hB;
    step(hs);
    chk("bub_b_hs", hs, 1);
    in_valid = 1'b0;
    chk("bub_in_ready", in_ready, 0);
    chk("bub_out_data", out_data, model_vec(bub_a));
    chk("bub_out_tag", out_tag, 4'hA);
    drain();

    // Reset mid-stream with 2 beats in flight
    out_ready = 1'b0;
    send(DW'($urandom), 4'd1);
    send(DW'($urandom), 4'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_beat_cnt", beat_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid_after", out_valid, 0);

    // Random traffic with random backpressure
    rnd_ready = 1'b1; ready_pct = 50;
    rand_stream(150, 60);
    drain();
    rnd_ready = 1'b0;

    // Counter wrap: 65535 beats, then one more
    out_ready = 1'b1;
    cnt_clr = 1'b1; step(hs); cnt_clr = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    while (idx < 65535) begin
      in_data = DW'($urandom); in_tag = TAG_W'($urandom);
      step(hs);
      if (hs) idx++;
    end
    in_valid = 1'b0;
    drain();
    chk("cnt_ffff", beat_cnt, 16'hFFFF);
    send(DW'($urandom), 4'd5);
    drain();
    chk("cnt_wrap", beat_cnt, 0);

    // Clear wins over a concurrent handshake
    for (int k = 0; k < 3; k++) send(DW'($urandom), 4'(k));
    drain();
    chk("cnt_pre_clr", beat_cnt, 3);
    out_ready = 1'b0;
    send(DW'($urandom), 4'd9);
    n = 0;
    while (!out_valid && n < 20) begin idle(1); n++; end
    chk("clr_parked", out_valid, 1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    step(hs);
    cnt_clr = 1'b0;
    chk("clr_wins", beat_cnt, 0);
    chk("clr_beat_taken", exp_q.size(), 0);

    drain();
    chk("leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
